// File: rtl/wall_clock_gen_if.sv
// Signal bundle for wall_clock_gen: set/mode controls in, time-of-day state and tick enables out.
interface wall_clock_gen_if;
    logic       fast_mode;
    logic       set_en;
    logic [4:0] set_hour;
    logic [5:0] set_min;
    logic       sec_tick;
    logic       min_tick;
    logic       hour_tick;
    logic       day_tick;
    logic       sec_half;
    logic [5:0] seconds;
    logic [5:0] minutes;
    logic [4:0] hours;
    logic       set_err;

    modport master (
        output fast_mode, set_en, set_hour, set_min,
        input  sec_tick, min_tick, hour_tick, day_tick, sec_half,
               seconds, minutes, hours, set_err
    );

    modport slave (
        input  fast_mode, set_en, set_hour, set_min,
        output sec_tick, min_tick, hour_tick, day_tick, sec_half,
               seconds, minutes, hours, set_err
    );
endinterface

// File: rtl/wall_clock_gen.sv
// Time-of-day generator: divides clk256 into second/minute/hour/day tick enables
// and keeps 24 h binary counters with a synchronous set and a fast-advance mode.
module wall_clock_gen #(
    parameter int unsigned CLK_HZ = 256
) (
    input  logic            clk256,
    input  logic            reset,
    wall_clock_gen_if.slave bus
);
    localparam int unsigned PW = $clog2(CLK_HZ);
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0] PRE_HALF = PW'(CLK_HZ / 2);

    logic [PW-1:0] presc;
    logic [5:0]    sec_q, min_q;
    logic [4:0]    hr_q;
    logic          sec_tick_q, min_tick_q, hour_tick_q, day_tick_q, set_err_q;

    logic          advance, set_ok;
    logic [5:0]    sec_n, min_n;
    logic [4:0]    hr_n;
    logic          s_t, m_t, h_t, d_t;

    assign advance = (presc == PRE_MAX);
    assign set_ok  = bus.set_en && (bus.set_hour <= 5'd23) && (bus.set_min <= 6'd59);

    // Carry chain: fast mode forces a minute carry on every advance.
    always_comb begin
        sec_n = sec_q;
        min_n = min_q;
        hr_n  = hr_q;
        s_t   = 1'b0;
        m_t   = 1'b0;
        h_t   = 1'b0;
        d_t   = 1'b0;
        if (advance) begin
            s_t = 1'b1;
            if (bus.fast_mode || sec_q == 6'd59) begin
                sec_n = '0;
                m_t   = 1'b1;
            end else begin
                sec_n = sec_q + 6'd1;
            end
            if (m_t) begin
                if (min_q == 6'd59) begin
                    min_n = '0;
                    h_t   = 1'b1;
                end else begin
                    min_n = min_q + 6'd1;
                end
            end
            if (h_t) begin
                if (hr_q == 5'd23) begin
                    hr_n = '0;
                    d_t  = 1'b1;
                end else begin
                    hr_n = hr_q + 5'd1;
                end
            end
        end
    end

    always_ff @(posedge clk256 or posedge reset) begin
        if (reset) begin
            presc       <= '0;
            sec_q       <= '0;
            min_q       <= '0;
            hr_q        <= '0;
            sec_tick_q  <= 1'b0;
            min_tick_q  <= 1'b0;
            hour_tick_q <= 1'b0;
            day_tick_q  <= 1'b0;
            set_err_q   <= 1'b0;
        end else if (set_ok) begin
            // A valid load overrides any advance on the same edge.
            presc       <= '0;
            sec_q       <= '0;
            min_q       <= bus.set_min;
            hr_q        <= bus.set_hour;
            sec_tick_q  <= 1'b0;
            min_tick_q  <= 1'b0;
            hour_tick_q <= 1'b0;
            day_tick_q  <= 1'b0;
            set_err_q   <= 1'b0;
        end else begin
            presc       <= advance ? '0 : presc + PW'(1);
            sec_q       <= sec_n;
            min_q       <= min_n;
            hr_q        <= hr_n;
            sec_tick_q  <= s_t;
            min_tick_q  <= m_t;
            hour_tick_q <= h_t;
            day_tick_q  <= d_t;
            set_err_q   <= bus.set_en;
        end
    end

    assign bus.sec_half  = (presc < PRE_HALF);
    assign bus.sec_tick  = sec_tick_q;
    assign bus.min_tick  = min_tick_q;
    assign bus.hour_tick = hour_tick_q;
    assign bus.day_tick  = day_tick_q;
    assign bus.set_err   = set_err_q;
    assign bus.seconds   = sec_q;
    assign bus.minutes   = min_q;
    assign bus.hours     = hr_q;
endmodule
